// File: rtl/cas4_unsort.sv
// cas4_unsort: restores original lane order after a 4-input sort stage.
// It collects four tagged values, one per beat. It then emits them in
// position order 0..3, one per beat, with a valid/ready handshake.
// Optional feature: define CAS4_UNSORT_TAG_CHECK_EN to add the sticky err_dup
// flag. The flag is raised when a tag repeats within a frame.
module cas4_unsort #(
    parameter int unsigned SNG_WIDTH = 8,
    parameter int unsigned NUM_LANES = 4  // fixed at 4: tags are 2 bits wide
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SNG_WIDTH-1:0] in_data,
    input  logic [1:0]           in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SNG_WIDTH-1:0] out_data,
    output logic [1:0]           out_idx,
    output logic                 out_last,
    output logic                 busy
`ifdef CAS4_UNSORT_TAG_CHECK_EN
    ,
    output logic                 err_dup
`endif
);

    typedef enum logic [0:0] {StCollect, StEmit} state_e;

    state_e               state_q;
    logic [1:0]           count_q;
    logic [1:0]           rd_idx_q;
    logic [NUM_LANES-1:0] present_q;
    logic [SNG_WIDTH-1:0] data_q [NUM_LANES];
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 out_last_q;

    logic accept;
    logic fire;

    assign accept = in_valid && in_ready_q;
    assign fire   = out_valid_q && out_ready;

    // Frame FSM: collect four beats into slots by tag, then drain the slots in index order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StCollect;
            count_q     <= 2'd0;
            rd_idx_q    <= 2'd0;
            present_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            case (state_q)
                StCollect: begin
                    if (accept) begin
                        // A repeated tag simply overwrites the earlier value.
                        data_q[in_tag]    <= in_data;
                        present_q[in_tag] <= 1'b1;
                        if (count_q == 2'd3) begin
                            count_q     <= 2'd0;
                            state_q     <= StEmit;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= 1'b0;
                        end else begin
                            count_q <= count_q + 2'd1;
                        end
                    end
                end
                StEmit: begin
                    if (fire) begin
                        if (rd_idx_q == 2'd3) begin
                            rd_idx_q    <= 2'd0;
                            present_q   <= '0;
                            state_q     <= StCollect;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            rd_idx_q   <= rd_idx_q + 2'd1;
                            out_last_q <= (rd_idx_q == 2'd2);
                        end
                    end
                end
                default: state_q <= StCollect;
            endcase
        end
    end

`ifdef CAS4_UNSORT_TAG_CHECK_EN
    logic err_dup_q;

    // Sticky duplicate-tag flag; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_dup_q <= 1'b0;
        end else if (accept && present_q[in_tag]) begin
            err_dup_q <= 1'b1;
        end
    end

    assign err_dup = err_dup_q;
`endif

    // Output decode from registered state only; data is forced to 0 outside EMIT and for empty slots.
    always_comb begin
        out_data = '0;
        if (state_q == StEmit && present_q[rd_idx_q]) begin
            out_data = data_q[rd_idx_q];
        end
    end

    assign out_idx   = rd_idx_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (count_q != 2'd0) || (state_q == StEmit);

endmodule
